// File: rtl/reg_file_port_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_port_ctrl_if
// Purpose  : Groups the operand-read handshake, the writeback handshake and
//            the shared register-file port of reg_file_port_ctrl.
// Modports : slave  - the port controller (accepts requests, drives reg_*)
//            master - its environment (datapath requester + register file)
// Signals  : rd_valid/rd_ready/rd_addr_a/rd_addr_b  operand-read request
//            op_valid/op_ready/op_a/op_b            operand response
//            wb_valid/wb_ready/wb_addr/wb_data      writeback request
//            reg_addr1/reg_addr2/reg_din/reg_wr     register-file port
//            reg_out_1/reg_out_2                    register-file read data
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_port_ctrl_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic [4:0]  reg_addr1;
    logic [4:0]  reg_addr2;
    logic [15:0] reg_din;
    logic        reg_wr;
    logic [15:0] reg_out_1;
    logic [15:0] reg_out_2;

    modport slave (
        input  rd_valid, rd_addr_a, rd_addr_b, op_ready,
               wb_valid, wb_addr, wb_data, reg_out_1, reg_out_2,
        output rd_ready, op_valid, op_a, op_b, wb_ready,
               reg_addr1, reg_addr2, reg_din, reg_wr
    );

    modport master (
        output rd_valid, rd_addr_a, rd_addr_b, op_ready,
               wb_valid, wb_addr, wb_data, reg_out_1, reg_out_2,
        input  rd_ready, op_valid, op_a, op_b, wb_ready,
               reg_addr1, reg_addr2, reg_din, reg_wr
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_port_ctrl
// Purpose  : Requester-side sequencer for the 32x16 register file. Operand
//            reads own the shared port for one FETCH cycle; writebacks are
//            buffered in a FIFO and drained whenever no read needs the port.
//            Reads that hit a buffered write are forwarded from the FIFO.
// Ports    : clk  - system clock, all state on posedge
//            rst  - synchronous active-high reset
//            bus  - reg_file_port_ctrl_if.slave (request/response/reg port)
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_port_ctrl #(
    parameter int WB_DEPTH = 2
) (
    input wire logic            clk,
    input wire logic            rst,
    reg_file_port_ctrl_if.slave bus
);

    localparam int c_PTR_W = $clog2(WB_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [4:0]         r_fifo_addr [WB_DEPTH];
    logic [15:0]        r_fifo_data [WB_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_rd_ready;
    logic               w_rd_hs;
    logic               w_op_hs;
    logic               w_push;
    logic               w_pop;

    logic [c_PTR_W-1:0] w_idx;
    logic               w_fwd_a_hit;
    logic               w_fwd_b_hit;
    logic [15:0]        w_fwd_a_data;
    logic [15:0]        w_fwd_b_data;
    logic               r_fwd_a_hit;
    logic               r_fwd_b_hit;
    logic [15:0]        r_fwd_a_data;
    logic [15:0]        r_fwd_b_data;

    logic               r_op_valid;
    logic [15:0]        r_op_a;
    logic [15:0]        r_op_b;
    logic [4:0]         r_reg_addr1;
    logic [4:0]         r_reg_addr2;
    logic [15:0]        r_reg_din;
    logic               r_reg_wr;

    assign w_full     = (r_count == c_CNT_W'(WB_DEPTH));
    assign w_empty    = (r_count == '0);
    // A full FIFO blocks new reads so the drain always gets the port.
    assign w_rd_ready = (r_state == c_ST_IDLE) && !w_full;
    assign w_rd_hs    = bus.rd_valid && w_rd_ready;
    assign w_op_hs    = r_op_valid && bus.op_ready;
    assign w_push     = bus.wb_valid && !w_full;

    assign bus.rd_ready  = w_rd_ready;
    assign bus.wb_ready  = !w_full;
    assign bus.op_valid  = r_op_valid;
    assign bus.op_a      = r_op_a;
    assign bus.op_b      = r_op_b;
    assign bus.reg_addr1 = r_reg_addr1;
    assign bus.reg_addr2 = r_reg_addr2;
    assign bus.reg_din   = r_reg_din;
    assign bus.reg_wr    = r_reg_wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and drain decision. A read handshake takes priority over the
    // drain in IDLE; FETCH never drains because the port carries the read.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (w_rd_hs) begin
                    w_state_nxt = c_ST_FETCH;
                end else begin
                    w_pop = !w_empty;
                end
            end
            c_ST_FETCH: begin
                w_state_nxt = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                w_pop = !w_empty;
                if (w_op_hs) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Forwarding search, oldest to youngest so the youngest match wins.
    // Only pre-push contents are searched: a same-edge writeback is not seen.
    always_comb begin
        w_idx        = '0;
        w_fwd_a_hit  = 1'b0;
        w_fwd_b_hit  = 1'b0;
        w_fwd_a_data = '0;
        w_fwd_b_data = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            w_idx = r_rd_ptr + c_PTR_W'(i);
            if (c_CNT_W'(i) < r_count) begin
                if (r_fifo_addr[w_idx] == bus.rd_addr_a) begin
                    w_fwd_a_hit  = 1'b1;
                    w_fwd_a_data = r_fifo_data[w_idx];
                end
                if (r_fifo_addr[w_idx] == bus.rd_addr_b) begin
                    w_fwd_b_hit  = 1'b1;
                    w_fwd_b_data = r_fifo_data[w_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= bus.wb_addr;
                r_fifo_data[r_wr_ptr] <= bus.wb_data;
                r_wr_ptr              <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg_wr     <= 1'b0;
            r_reg_addr1  <= '0;
            r_reg_addr2  <= '0;
            r_reg_din    <= '0;
            r_fwd_a_hit  <= 1'b0;
            r_fwd_b_hit  <= 1'b0;
            r_fwd_a_data <= '0;
            r_fwd_b_data <= '0;
            r_op_valid   <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
        end else begin
            r_reg_wr <= w_pop;
            if (w_rd_hs) begin
                r_reg_addr1  <= bus.rd_addr_a;
                r_reg_addr2  <= bus.rd_addr_b;
                r_fwd_a_hit  <= w_fwd_a_hit;
                r_fwd_b_hit  <= w_fwd_b_hit;
                r_fwd_a_data <= w_fwd_a_data;
                r_fwd_b_data <= w_fwd_b_data;
            end else if (w_pop) begin
                r_reg_addr1 <= r_fifo_addr[r_rd_ptr];
                r_reg_din   <= r_fifo_data[r_rd_ptr];
            end
            // The register file read on the FETCH negedge is stable here.
            if (r_state == c_ST_FETCH) begin
                r_op_valid <= 1'b1;
                r_op_a     <= r_fwd_a_hit ? r_fwd_a_data : bus.reg_out_1;
                r_op_b     <= r_fwd_b_hit ? r_fwd_b_data : bus.reg_out_2;
            end else if (w_op_hs) begin
                r_op_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_port_ctrl
// Purpose  : Self-checking bench for reg_file_port_ctrl. Holds a register
//            file model, an architectural-state reference and directed tests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_port_ctrl;

    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    reg_file_port_ctrl_if bus();

    reg_file_port_ctrl #(
        .WB_DEPTH (DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem  [32];   // register file contents
    logic [15:0] arch [32];   // architectural register values
    logic [20:0] pend_q [$];  // accepted, not yet written writebacks {addr,data}
    logic [31:0] exp_q  [$];  // outstanding read results {op_a,op_b}
    bit          in_fetch;
    bit          exp_pop;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Register file acts on negedge; reference model checks every cycle.
    always @(negedge clk) begin
        bit hs;
        bit push;
        bit exp_opv;
        bit exp_wbr;
        bit exp_rdr;
        if (bus.reg_wr) mem[bus.reg_addr1] = bus.reg_din;
        bus.reg_out_1 <= mem[bus.reg_addr1];
        bus.reg_out_2 <= mem[bus.reg_addr2];
        if (rst) begin
            for (int i = 0; i < 32; i++) arch[i] = mem[i];
            pend_q.delete();
            exp_q.delete();
            in_fetch = 1'b0;
            exp_pop  = 1'b0;
        end else begin
            check("m_reg_wr", {31'd0, bus.reg_wr}, {31'd0, exp_pop});
            if (bus.reg_wr) begin
                if (pend_q.size() == 0) begin
                    check("m_drain_empty", 32'd1, 32'd0);
                end else begin
                    check("m_drain_addr", {27'd0, bus.reg_addr1}, {27'd0, pend_q[0][20:16]});
                    check("m_drain_data", {16'd0, bus.reg_din}, {16'd0, pend_q[0][15:0]});
                    void'(pend_q.pop_front());
                end
            end
            exp_wbr = (pend_q.size() < DEPTH);
            exp_rdr = (exp_q.size() == 0) && exp_wbr;
            exp_opv = (exp_q.size() != 0) && !in_fetch;
            check("m_wb_ready", {31'd0, bus.wb_ready}, {31'd0, exp_wbr});
            check("m_rd_ready", {31'd0, bus.rd_ready}, {31'd0, exp_rdr});
            check("m_op_valid", {31'd0, bus.op_valid}, {31'd0, exp_opv});
            if (exp_opv) begin
                check("m_op_a", {16'd0, bus.op_a}, {16'd0, exp_q[0][31:16]});
                check("m_op_b", {16'd0, bus.op_b}, {16'd0, exp_q[0][15:0]});
            end
            hs      = bus.rd_valid && exp_rdr;
            push    = bus.wb_valid && exp_wbr;
            exp_pop = (pend_q.size() > 0) && !hs && !in_fetch;
            if (exp_opv && bus.op_ready) void'(exp_q.pop_front());
            if (hs) exp_q.push_back({arch[bus.rd_addr_a], arch[bus.rd_addr_b]});
            if (push) begin
                pend_q.push_back({bus.wb_addr, bus.wb_data});
                arch[bus.wb_addr] = bus.wb_data;
            end
            in_fetch = hs;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [4:0] a, input logic [15:0] d);
        bit ok = 1'b0;
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        bus.wb_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.wb_ready;
        end
        check("push_accept", {31'd0, ok}, 32'd1);
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b);
        bit ok = 1'b0;
        bus.rd_valid  = 1'b1;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.rd_ready;
        end
        check("read_accept", {31'd0, ok}, 32'd1);
        tick();
        bus.rd_valid = 1'b0;
    endtask

    // Called right after the handshake edge: FETCH cycle, then operands.
    task automatic expect_ops(input string name, input logic [15:0] ea, input logic [15:0] eb);
        @(negedge clk);
        check({name, "_fetch_valid"}, {31'd0, bus.op_valid}, 32'd0);
        @(negedge clk);
        check({name, "_valid"}, {31'd0, bus.op_valid}, 32'd1);
        check({name, "_op_a"}, {16'd0, bus.op_a}, {16'd0, ea});
        check({name, "_op_b"}, {16'd0, bus.op_b}, {16'd0, eb});
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_rd_ready"}, {31'd0, bus.rd_ready}, 32'd1);
        check({name, "_wb_ready"}, {31'd0, bus.wb_ready}, 32'd1);
        check({name, "_op_valid"}, {31'd0, bus.op_valid}, 32'd0);
        check({name, "_op_a"}, {16'd0, bus.op_a}, 32'd0);
        check({name, "_op_b"}, {16'd0, bus.op_b}, 32'd0);
        check({name, "_reg_wr"}, {31'd0, bus.reg_wr}, 32'd0);
        check({name, "_reg_addr1"}, {27'd0, bus.reg_addr1}, 32'd0);
        check({name, "_reg_addr2"}, {27'd0, bus.reg_addr2}, 32'd0);
        check({name, "_reg_din"}, {16'd0, bus.reg_din}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'h1000 + 16'(i);
        rst           = 1'b1;
        bus.rd_valid  = 1'b0;
        bus.rd_addr_a = '0;
        bus.rd_addr_b = '0;
        bus.op_ready  = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        tick();
        rst = 1'b0;
        tick();

        // Write then read
        do_push(5'd5, 16'h1234);
        @(negedge clk);
        check("wr_no_early_pulse", {31'd0, bus.reg_wr}, 32'd0);
        @(negedge clk);
        check("wr_pulse", {31'd0, bus.reg_wr}, 32'd1);
        check("wr_addr", {27'd0, bus.reg_addr1}, 32'd5);
        check("wr_din", {16'd0, bus.reg_din}, 32'h1234);
        tick();
        do_read(5'd5, 5'd5);
        expect_ops("wr_rd", 16'h1234, 16'h1234);
        tick();

        // Forwarding: two r7 writes buffered behind a read, youngest wins
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd0; bus.rd_addr_b = 5'd1;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 16'h3333;
        @(negedge clk);
        check("fwd_first_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
        tick();
        bus.rd_valid = 1'b0;
        bus.wb_addr = 5'd7; bus.wb_data = 16'hBEEF;
        tick();
        bus.wb_data = 16'hCAFE;
        tick();
        bus.wb_valid = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd7; bus.rd_addr_b = 5'd2;
        @(negedge clk);
        check("fwd_rd_ready", {31'd0, bus.rd_ready}, 32'd1);
        tick();
        bus.rd_valid = 1'b0;
        expect_ops("fwd", 16'hCAFE, 16'h1002);
        tick();

        // Same-edge ordering
        do_push(5'd9, 16'h0001);
        repeat (4) tick();
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd9; bus.rd_addr_b = 5'd9;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 16'h00FF;
        @(negedge clk);
        check("same_edge_both_ready", {30'd0, bus.rd_ready, bus.wb_ready}, 32'd3);
        tick();
        bus.rd_valid = 1'b0; bus.wb_valid = 1'b0;
        expect_ops("same_edge", 16'h0001, 16'h0001);
        repeat (4) tick();
        do_read(5'd9, 5'd9);
        expect_ops("same_edge_later", 16'h00FF, 16'h00FF);
        tick();

        // Full FIFO: continuous writebacks with two reads stealing the port
        for (int k = 0; k < 5; k++) begin
            bus.wb_valid  = 1'b1;
            bus.wb_addr   = 5'(16 + k);
            bus.wb_data   = 16'hA000 + 16'(k);
            bus.rd_valid  = (k == 0) || (k == 3);
            bus.rd_addr_a = 5'(k);
            bus.rd_addr_b = 5'(k);
            tick();
        end
        bus.wb_valid = 1'b0; bus.rd_valid = 1'b0;
        @(negedge clk);
        check("full_wb_ready", {31'd0, bus.wb_ready}, 32'd0);
        check("full_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
        check("full_no_drain_in_fetch", {31'd0, bus.reg_wr}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("full_drain_wr", {31'd0, bus.reg_wr}, 32'd1);
            check("full_drain_addr", {27'd0, bus.reg_addr1}, 32'(17 + i));
            if (i == 0) check("full_rd_ready_back", {31'd0, bus.rd_ready}, 32'd1);
        end
        @(negedge clk);
        check("full_drain_done", {31'd0, bus.reg_wr}, 32'd0);
        tick();

        // Backpressure in HOLD while two writebacks drain
        bus.op_ready = 1'b0;
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd20; bus.rd_addr_b = 5'd16;
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd11; bus.wb_data = 16'h1111;
        tick();
        bus.rd_valid = 1'b0;
        bus.wb_addr = 5'd12; bus.wb_data = 16'h2222;
        tick();
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_op_valid", {31'd0, bus.op_valid}, 32'd1);
            check("bp_op_a", {16'd0, bus.op_a}, 32'hA004);
            check("bp_op_b", {16'd0, bus.op_b}, 32'hA000);
            check("bp_rd_ready", {31'd0, bus.rd_ready}, 32'd0);
            if (i == 1) check("bp_drain1", {26'd0, bus.reg_wr, bus.reg_addr1}, 32'h2B);
            if (i == 2) check("bp_drain2", {26'd0, bus.reg_wr, bus.reg_addr1}, 32'h2C);
        end
        tick();
        bus.op_ready = 1'b1;
        tick();
        do_read(5'd11, 5'd12);
        expect_ops("bp_readback", 16'h1111, 16'h2222);
        tick();

        // Reset in FETCH with two writebacks pending
        bus.wb_valid = 1'b1; bus.wb_addr = 5'd25; bus.wb_data = 16'hDEAD;
        tick();
        bus.wb_addr = 5'd26; bus.wb_data = 16'hBEEF;
        bus.rd_valid = 1'b1; bus.rd_addr_a = 5'd3; bus.rd_addr_b = 5'd4;
        tick();
        bus.wb_valid = 1'b0; bus.rd_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        @(negedge clk);
        check("midrst_no_wr1", {31'd0, bus.reg_wr}, 32'd0);
        @(negedge clk);
        check("midrst_no_wr2", {31'd0, bus.reg_wr}, 32'd0);

        // Final register file contents
        repeat (4) tick();
        @(negedge clk);
        for (int i = 0; i < 32; i++) check("regfile_vs_model", {16'd0, mem[i]}, {16'd0, arch[i]});
        check("final_r5", {16'd0, mem[5]}, 32'h1234);
        check("final_r7", {16'd0, mem[7]}, 32'hCAFE);
        check("final_r9", {16'd0, mem[9]}, 32'h00FF);
        check("final_r25", {16'd0, mem[25]}, 32'h1019);
        check("final_r26", {16'd0, mem[26]}, 32'h101A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_port_ctrl.md
# reg_file_port_ctrl

Requester-side sequencer for the 16-bit processor's 32x16 register file (`reg_file`). It accepts operand-read requests and writeback requests from the datapath and drives the register file's shared-address, negedge-sampled port (`reg_addr1`, `reg_addr2`, `reg_din`, `reg_wr`). Writebacks are buffered in a small FIFO and drained in cycles when no read is using the port. Reads that hit a buffered write are forwarded from the FIFO.

## Interface
- `WB_DEPTH`, default 2: writeback FIFO depth; power of 2, range 2..8.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `rd_valid`  in  1  operand-read request valid.
- `rd_ready`  out  1  read request accepted when high with `rd_valid`.
- `rd_addr_a`, `rd_addr_b`  in  5  source register addresses.
- `op_valid`  out  1  operands valid; held until `op_ready`.
- `op_ready`  in  1  consumer takes the operands.
- `op_a`, `op_b`  out  16  operand data for `rd_addr_a` / `rd_addr_b`.
- `wb_valid`  in  1  writeback request valid.
- `wb_ready`  out  1  FIFO can accept the writeback.
- `wb_addr`  in  5  destination register.
- `wb_data`  in  16  writeback data.
- `reg_addr1`, `reg_addr2`  out  5  register file addresses; `reg_addr1` is also the write address.
- `reg_din`  out  16  register file write data.
- `reg_wr`  out  1  1 = write `reg_din` to `reg_addr1`; 0 = read.
- `reg_out_1`, `reg_out_2`  in  16  register file read data, updated by the register file on negedge.

## Operation
- All `reg_*` outputs are registered on posedge. The register file acts on the following negedge. Data it reads is therefore stable at the next posedge.
- FSM states: IDLE, FETCH, HOLD.
  - **IDLE**
    - `rd_ready = !fifo_full`.
    - On the read handshake: drive `reg_addr1=rd_addr_a`, `reg_addr2=rd_addr_b`, `reg_wr=0`, and go to FETCH.
    - Otherwise, if the FIFO is non-empty: drive `reg_wr=1`, `reg_addr1=head.addr`, `reg_din=head.data`, and pop the FIFO.
    - Otherwise: drive `reg_wr=0` and hold the addresses.
  - **FETCH** (exactly 1 cycle)
    - The port is reserved for the read; no drain occurs.
    - Next posedge: capture operands, set `op_valid=1`, and go to HOLD.
  - **HOLD**
    - `rd_ready=0`.
    - The FIFO drains one entry per cycle, as in IDLE.
    - On `op_valid && op_ready`: clear `op_valid` and go to IDLE.
- `rd_ready` is 0 in FETCH and HOLD. Maximum read rate is one request per 3 cycles.
- A full FIFO blocks new reads (`rd_ready=0`), so draining always makes progress.
- Writeback FIFO:
  - `wb_ready = !fifo_full`.
  - Push on `wb_valid && wb_ready`.
  - At most one pop per cycle.
  - A simultaneous push and pop is legal, including when the FIFO is full: `wb_ready` is still 0 in that case, so no push occurs.
- Forwarding:
  - At the read handshake posedge, each of `rd_addr_a` and `rd_addr_b` is compared against all valid FIFO entries.
  - If there are multiple matches, the youngest entry wins.
  - The match flag and data are captured at that edge. At capture, a forwarded operand uses the FIFO data; otherwise it uses `reg_out_1` / `reg_out_2`.
- Write ordering:
  - A writeback accepted on the same posedge as a read handshake is **not** visible to that read; the read returns the prior value.
  - Writes already popped are visible to the register file before any later FETCH negedge.
- Register 0 is an ordinary register; there is no hardwired zero.

## Timing
- Reset values: state IDLE, FIFO empty, `rd_ready=1`, `wb_ready=1`, `op_valid=0`, `op_a=op_b=0`, `reg_wr=0`, `reg_addr1=reg_addr2=0`, `reg_din=0`.
- Read latency: handshake at posedge P0 → `op_valid` high from P1 (1 cycle), provided `op_ready` is held high.
- Writeback latency: push at P0 → earliest `reg_wr=1` from P1 (FIFO empty, state IDLE or HOLD, no read at P1). The register file updates at the negedge in [P1, P2).
- `reg_wr` is high for exactly 1 cycle per drained entry. Back-to-back entries drain on consecutive cycles.
- `op_a`, `op_b` and `op_valid` are stable while `op_valid && !op_ready`.
- Reset mid-operation (in FETCH or HOLD, or with the FIFO non-empty):
  - The in-flight read and all buffered writes are discarded.
  - Outputs return to their reset values on the next posedge.

## Test plan
- **Write then read:** push wb (r5, 0x1234); wait for the `reg_wr` pulse; read a=r5, b=r5 → `op_a=op_b=0x1234`, `op_valid` 1 cycle after the handshake.
- **Forwarding:** push wb (r7, 0xBEEF) then wb (r7, 0xCAFE) on consecutive cycles; issue a read a=r7, b=r2 before either drains → `op_a=0xCAFE`, `op_b` = register file r2 value.
- **Same-edge ordering:** with r9=0x0001 in the register file, push wb (r9, 0x00FF) on the same posedge as the read handshake for r9 → `op_a=0x0001`; a later read returns 0x00FF.
- **Full FIFO:** push `WB_DEPTH` writebacks with the read held off → `wb_ready=0` and `rd_ready=0`; drain proceeds with one `reg_wr` per cycle; `rd_ready` returns to 1 after the first pop.
- **Backpressure:** hold `op_ready=0` for 5 cycles in HOLD while 2 writebacks drain → operands stay stable, `rd_ready=0`, both writes reach the register file.
- **Reset mid-operation:** assert `rst` in FETCH with 2 FIFO entries pending → next cycle all outputs are at reset values and no `reg_wr` pulse occurs.
